// File: rtl/scene_pkg.sv
// scene_pkg: game-state encoding, compositor layer indices and per-state layer masks
package scene_pkg;
  typedef enum logic [2:0] {ST_TITLE, ST_READY, ST_CHARGE, ST_JUMP, ST_OVER} state_e;
  localparam int LYR_BG    = 0;
  localparam int LYR_FAR   = 1;
  localparam int LYR_NEAR  = 2;
  localparam int LYR_CHAR  = 3;
  localparam int LYR_TITLE = 4;
  localparam int LYR_OVER  = 5;
  localparam logic [5:0] LAYER_TITLE = 6'h11;
  localparam logic [5:0] LAYER_PLAY  = 6'h0F;
  localparam logic [5:0] LAYER_OVER  = 6'h2F;
  function automatic logic [5:0] layer_of(input state_e s);
    return s == ST_TITLE ? LAYER_TITLE : s == ST_OVER ? LAYER_OVER : LAYER_PLAY;
  endfunction
endpackage

// File: rtl/scene_layer_ctrl_anim_stepper.sv
// anim_stepper: jump animation index, advanced once every FRAMES_PER_STEP enabled frames
module anim_stepper #(
  parameter int ANIM_FRAMES     = 15,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] frame_o,
  output logic       done_o
);
  localparam int SW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  logic [SW-1:0] step_q, step_d;
  logic [3:0] frame_q, frame_d;
  logic wrap;
  always_comb begin
    wrap = step_q == SW'(FRAMES_PER_STEP - 1);
    done_o = wrap && frame_q == 4'(ANIM_FRAMES - 1);
    step_d = clr_i ? '0 : en_i ? (wrap ? '0 : step_q + 1'b1) : step_q;
    frame_d = clr_i ? '0 : (en_i && wrap && !done_o) ? frame_q + 1'b1 : frame_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step_q <= '0;
      frame_q <= '0;
    end else begin
      step_q <= step_d;
      frame_q <= frame_d;
    end
  assign frame_o = frame_q;
endmodule

// File: rtl/scene_layer_ctrl.sv
// scene_layer_ctrl: frame-synchronous game-state sequencer selecting compositor layers.
// SCENE_TITLE_BLINK_EN blinks the title layer with a 32-frame period.
module scene_layer_ctrl
  import scene_pkg::*;
#(
  parameter int ANIM_FRAMES     = 15,
  parameter int FRAMES_PER_STEP = 2,
  parameter int CHARGE_W        = 6,
  parameter int CHARGE_MAX      = 63
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                key,
  input  logic                land_ok,
  output logic [5:0]          layer_en,
  output logic [3:0]          anim_frame,
  output logic [CHARGE_W-1:0] charge,
  output logic                jump_active,
  output logic                jump_done,
  output logic                score_inc
);
  state_e state_q, state_d;
  logic key_prev_q, press, rel;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic [5:0] layer_en_q, layer_en_d;
  logic jump_active_q, jump_done_q, score_inc_q;
  logic anim_done, anim_en, anim_clr, jump_end;
  assign press = key && !key_prev_q;
  assign rel = !key && key_prev_q;
  assign jump_end = frame_start && state_q == ST_JUMP && anim_done;
  assign anim_en = frame_start && state_q == ST_JUMP;
  assign anim_clr = frame_start && (state_d == ST_READY || (state_q == ST_CHARGE && state_d == ST_JUMP));
  always_comb begin
    state_d = state_q;
    charge_d = charge_q;
    if (frame_start)
      case (state_q)
        ST_TITLE, ST_OVER: if (press) begin
          state_d = ST_READY;
          charge_d = '0;
        end
        ST_READY: if (press) begin
          state_d = ST_CHARGE;
          charge_d = CHARGE_W'(1);
        end
        ST_CHARGE:
          if (rel) state_d = ST_JUMP;
          else if (key) charge_d = charge_q == CHARGE_W'(CHARGE_MAX) ? charge_q : charge_q + 1'b1;
        ST_JUMP: if (anim_done) begin
          state_d = land_ok ? ST_READY : ST_OVER;
          charge_d = land_ok ? '0 : charge_q;
        end
        default: state_d = ST_TITLE;
      endcase
  end
`ifdef SCENE_TITLE_BLINK_EN
  logic [4:0] blink_q, blink_d;
  always_comb begin
    blink_d = state_q != ST_TITLE ? '0 : frame_start ? blink_q + 1'b1 : blink_q;
    layer_en_d = layer_of(state_d);
    if (state_d == ST_TITLE) layer_en_d[LYR_TITLE] = blink_d[4];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blink_q <= '0;
    else blink_q <= blink_d;
`else
  always_comb layer_en_d = layer_of(state_d);
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_TITLE;
      key_prev_q <= 1'b0;
      charge_q <= '0;
      layer_en_q <= LAYER_TITLE;
      jump_active_q <= 1'b0;
      jump_done_q <= 1'b0;
      score_inc_q <= 1'b0;
    end else begin
      jump_done_q <= jump_end;
      score_inc_q <= jump_end && land_ok;
      if (frame_start) begin
        state_q <= state_d;
        key_prev_q <= key;
        charge_q <= charge_d;
        layer_en_q <= layer_en_d;
        jump_active_q <= state_d == ST_JUMP;
      end
    end
  anim_stepper #(.ANIM_FRAMES(ANIM_FRAMES), .FRAMES_PER_STEP(FRAMES_PER_STEP)) u_anim (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(anim_clr),
    .en_i(anim_en),
    .frame_o(anim_frame),
    .done_o(anim_done)
  );
  assign layer_en = layer_en_q;
  assign charge = charge_q;
  assign jump_active = jump_active_q;
  assign jump_done = jump_done_q;
  assign score_inc = score_inc_q;
endmodule

// File: tb/tb_scene_layer_ctrl.sv
// tb_scene_layer_ctrl: randomized scoreboard bench against a frame-level game model
module tb_scene_layer_ctrl;
  localparam int AF = 15, FPS = 2, CMAX = 63;
  localparam int M_TITLE = 0, M_READY = 1, M_CHARGE = 2, M_JUMP = 3, M_OVER = 4;
  typedef struct {
    logic [5:0] layer;
    logic [3:0] anim;
    logic [5:0] chg;
    logic ja, jd, sc;
  } exp_t;
  logic clk = 0, rst_n = 0, frame_start = 0, key = 0, land_ok = 0;
  logic [5:0] layer_en;
  logic [3:0] anim_frame;
  logic [5:0] charge;
  logic jump_active, jump_done, score_inc;
  int passed = 0, total = 0;
  int m, ch, jf, kp;
  exp_t sb[$];
  scene_layer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .key(key), .land_ok(land_ok),
    .layer_en(layer_en), .anim_frame(anim_frame), .charge(charge),
    .jump_active(jump_active), .jump_done(jump_done), .score_inc(score_inc)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s got %0h expected %0h", n, a, e);
  endtask
  function automatic int m_anim();
    int a = jf / FPS;
    return (m == M_JUMP || m == M_OVER) ? (a > AF - 1 ? AF - 1 : a) : 0;
  endfunction
  task automatic model_reset();
    m = M_TITLE; ch = 0; jf = 0; kp = 0;
  endtask
  task automatic model_frame(input int k, input int l);
    exp_t e;
    int pr = k & ~kp & 1, rl = ~k & kp & 1;
    e.jd = 0; e.sc = 0;
    kp = k;
    case (m)
      M_TITLE: if (pr) begin m = M_READY; ch = 0; end
      M_READY: if (pr) begin m = M_CHARGE; ch = 1; end
      M_CHARGE: if (rl) begin m = M_JUMP; jf = 0; end else if (k) ch = ch < CMAX ? ch + 1 : CMAX;
      M_JUMP: begin
        jf++;
        if (jf == AF * FPS) begin
          e.jd = 1;
          if (l) begin e.sc = 1; m = M_READY; ch = 0; jf = 0; end
          else m = M_OVER;
        end
      end
      default: if (pr) begin m = M_READY; ch = 0; jf = 0; end
    endcase
    e.layer = m == M_TITLE ? 6'h11 : m == M_OVER ? 6'h2F : 6'h0F;
    e.anim = 4'(m_anim());
    e.chg = 6'(ch);
    e.ja = m == M_JUMP;
    sb.push_back(e);
  endtask
  task automatic frame(input logic k, input logic l, input int gap);
    @(negedge clk);
    key = k; land_ok = l; frame_start = 1;
    model_frame(int'(k), int'(l));
    @(negedge clk);
    frame_start = 0;
    repeat (gap) @(negedge clk);
  endtask
  always @(posedge clk) begin
    if (frame_start) begin
      exp_t e;
      #2;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("layer_en", layer_en, e.layer);
        chk("anim_frame", anim_frame, e.anim);
        chk("charge", charge, e.chg);
        chk("jump_active", jump_active, e.ja);
        chk("jump_done", jump_done, e.jd);
        chk("score_inc", score_inc, e.sc);
      end
    end else begin
      #2;
      chk("jump_done_idle", jump_done, 0);
      chk("score_inc_idle", score_inc, 0);
    end
  end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_layer_en", layer_en, 6'h11);
    chk("rst_anim", anim_frame, 0);
    chk("rst_charge", charge, 0);
    chk("rst_jump_active", jump_active, 0);
    rst_n = 1;
    repeat (3) frame(0, 0, 1);
    frame(1, 0, 1);
    frame(0, 0, 1);
    repeat (5) frame(1, 0, 1);
    frame(0, 0, 1);
    repeat (AF * FPS) frame(0, 1, 1);
    frame(1, 0, 1);
    repeat (80) frame(1, 0, 0);
    frame(0, 0, 1);
    repeat (AF * FPS) frame(0, 0, 1);
    frame(1, 0, 1);
    frame(0, 0, 1);
    frame(1, 0, 1);
    repeat (3) frame(1, 0, 1);
    frame(0, 0, 1);
    repeat (14) frame(0, 1, 1);
    chk("pre_rst_anim", anim_frame, 32'(m_anim()));
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_layer_en", layer_en, 6'h11);
    chk("async_anim", anim_frame, 0);
    chk("async_charge", charge, 0);
    chk("async_jump_active", jump_active, 0);
    chk("async_jump_done", jump_done, 0);
    chk("async_score_inc", score_inc, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (20) frame(0, 1, 1);
    for (int i = 0; i < 600; i++)
      frame(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 1)), $urandom_range(0, 2));
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/scene_layer_ctrl.md
Name: scene_layer_ctrl

Overview:
- Frame-synchronous game-state sequencer for the VGA pixel compositor.
- Decides which compositor layers are active each frame: background, far block, near block, character, "jump" title, "game over" title.
- Drives the jump-animation frame index, the charge level and the landing handshake.
- All visible state changes occur only on frame boundaries, so no layer switch or animation step happens mid-frame (no tearing).

Parameters:
- ANIM_FRAMES, 15, number of jump-animation frames (index 0..ANIM_FRAMES-1).
- FRAMES_PER_STEP, 2, video frames each animation frame is held (>=1).
- CHARGE_W, 6, width of charge counter.
- CHARGE_MAX, 63, charge saturation value (<= 2^CHARGE_W-1).

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- key  in  1  debounced jump key level, 1 = pressed.
- land_ok  in  1  game-logic verdict, 1 = character landed on a block; sampled only at jump end.
- layer_en  out  6  bit0 bg, bit1 far block, bit2 near block, bit3 character, bit4 title, bit5 game-over.
- anim_frame  out  4  current jump-animation frame index.
- charge  out  CHARGE_W  accumulated charge, held through the jump.
- jump_active  out  1  high while in JUMP.
- jump_done  out  1  one-cycle pulse when the jump completes.
- score_inc  out  1  one-cycle pulse on a successful landing.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All registers clear immediately on rst_n=0, independent of clk.
- Reset values:
  - state=TITLE, layer_en=6'h11, anim_frame=0, charge=0.
  - jump_active=0, jump_done=0, score_inc=0.
  - key_prev=0, frame step counter=0.
- Evaluation timing:
  - All transitions and counter updates are evaluated only in the cycle where frame_start=1. Between pulses, everything holds.
  - key is sampled on frame_start. key_prev updates on every frame_start.
  - press = key & ~key_prev; release = ~key & key_prev.
- Registered outputs: layer_en, anim_frame, charge and jump_active are registered and take their new values the cycle after frame_start.
- layer_en per state:
  - TITLE = 6'h11.
  - READY, CHARGE, JUMP = 6'h0F.
  - OVER = 6'h2F.
- FSM:
  - TITLE: press -> READY; charge cleared.
  - READY:
    - key=1 -> CHARGE; charge=1.
    - A key already held on entry counts as a new charge only after a release (key_prev gating).
  - CHARGE:
    - key=1 -> charge=min(charge+1, CHARGE_MAX). Saturates with no wrap.
    - release -> JUMP; anim_frame=0, step counter=0.
  - JUMP:
    - The step counter counts frames. At FRAMES_PER_STEP-1 it clears and anim_frame increments.
    - When anim_frame=ANIM_FRAMES-1 and the step counter reaches FRAMES_PER_STEP-1: jump_done pulses and land_ok is sampled in the same cycle.
      - land_ok=1 -> score_inc pulses; go to READY, charge=0, anim_frame=0.
      - land_ok=0 -> OVER; anim_frame holds ANIM_FRAMES-1.
    - key is ignored in JUMP, but key_prev still tracks it.
  - OVER: press -> READY; charge=0, anim_frame=0.
- Pulse outputs: jump_done and score_inc are exactly one clk cycle wide, asserted the cycle after the qualifying frame_start.
- Boundary rules:
  - If press and release would both apply in one frame, no action is taken, since only one edge is possible per sample.
  - frame_start held high for multiple cycles is illegal; each high cycle is treated as a frame.
  - Reset mid-jump returns to TITLE with all outputs at reset values and no jump_done.

Optional Feature:
- Macro: SCENE_TITLE_BLINK_EN.
- Defined: in TITLE, a 5-bit frame counter free-runs on frame_start. layer_en[4] = counter[4], so the title blinks with a 32-frame period. The counter resets on rst_n and on entry to TITLE. All other states are unaffected.
- Undefined: no counter is present and layer_en[4] is constant 1 in TITLE.

Decomposition:
- Shared package scene_pkg holds:
  - the state encoding (TITLE, READY, CHARGE, JUMP, OVER);
  - layer bit indices (LYR_BG..LYR_OVER);
  - the per-state layer_en constants.
- The compositor consumes the same layer indices from scene_pkg.
- One natural sub-module, anim_stepper: step counter plus frame index with a done flag. It is parameterised by ANIM_FRAMES and FRAMES_PER_STEP.

Test Plan:
- Reset, then 3 frame_start pulses with key=0 -> state TITLE, layer_en=6'h11, anim_frame=0, charge=0.
- key high across 1 frame (TITLE->READY), low 1 frame, then high 5 frames, then low -> charge=5 on the release frame, layer_en=6'h0F, jump_active=1 the next cycle.
- key held 80 frames in CHARGE -> charge saturates at 63, no wrap.
- Full jump with defaults -> anim_frame steps 0..14, each held 2 frames (30 frames total). land_ok=1 -> jump_done and score_inc each 1 cycle, state READY, charge=0.
- Same jump with land_ok=0 -> jump_done only, layer_en=6'h2F, anim_frame=14. Then a key press -> READY.
- rst_n dropped asynchronously at anim_frame=7, mid-cycle -> outputs reset immediately, no jump_done. With SCENE_TITLE_BLINK_EN defined, layer_en[4] toggles every 16 frames in TITLE.
